// File: rtl/color_expand.sv
// color_expand: re-expands an 8-bit single-channel pixel stream to RGB565.
// Fixed 2-cycle pipeline. Mode changes take effect only at frame start (0,0).
// Optional build macro COLOR_EXPAND_HEATMAP_EN: modes 000/100 emit a heatmap
// instead of gray.
module color_expand #(
   parameter int CR_GAIN_SHIFT = 1
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic [7:0]  mod_pixel,
   input  logic        mod_valid,
   input  logic [10:0] mod_hcount,
   input  logic [9:0]  mod_vcount,
   input  logic [2:0]  selector,
   output logic [15:0] disp_pixel,
   output logic        disp_valid,
   output logic [10:0] disp_hcount,
   output logic [9:0]  disp_vcount,
   output logic [2:0]  sel_active
);

   // Wide enough that |v-128| << gain never wraps before saturation.
   localparam int MW = 9 + CR_GAIN_SHIFT;

   logic [2:0]  r_sel;
   logic [7:0]  r_v1;
   logic        r_vld1;
   logic [10:0] r_h1;
   logic [9:0]  r_vc1;
   logic [2:0]  r_mode1;

   logic        w_frame_start;
   logic [2:0]  w_mode;
   logic        w_hi;
   logic [8:0]  w_dist;
   logic [MW-1:0] w_scaled;
   logic [7:0]  w_m;
   logic [7:0]  w_r, w_g, w_b;
   logic [15:0] w_pack;
`ifdef COLOR_EXPAND_HEATMAP_EN
   logic [7:0]  w_f;
   logic [7:0]  w_hr, w_hg, w_hb;
`endif

   // The (0,0) pixel loads the new mode and is itself rendered in that mode.
   assign w_frame_start = mod_valid && (mod_hcount == 11'd0) && (mod_vcount == 10'd0);
   assign w_mode        = w_frame_start ? selector : r_sel;

   // Shadow selector, updated only at frame start.
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) r_sel <= 3'd0;
      else if (w_frame_start) r_sel <= selector;
   end

   // Stage 1: capture pixel, valid, counts and the mode to apply.
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         r_v1    <= 8'd0;
         r_vld1  <= 1'b0;
         r_h1    <= 11'd0;
         r_vc1   <= 10'd0;
         r_mode1 <= 3'd0;
      end else begin
         r_v1    <= mod_pixel;
         r_vld1  <= mod_valid;
         r_h1    <= mod_hcount;
         r_vc1   <= mod_vcount;
         r_mode1 <= w_mode;
      end
   end

   // Diverging magnitude around 128, scaled then saturated to 255.
   assign w_hi     = r_v1[7];
   assign w_dist   = w_hi ? ({1'b0, r_v1} - 9'd128) : (9'd128 - {1'b0, r_v1});
   assign w_scaled = MW'(w_dist) << CR_GAIN_SHIFT;
   assign w_m      = (w_scaled > MW'(255)) ? 8'hFF : w_scaled[7:0];

`ifdef COLOR_EXPAND_HEATMAP_EN
   // Heatmap: four linear ramps selected by the top two bits.
   assign w_f = {r_v1[5:0], 2'b00};
   always_comb begin
      w_hr = 8'd0;
      w_hg = 8'd0;
      w_hb = 8'd0;
      case (r_v1[7:6])
         2'd0: w_hb = w_f;
         2'd1: begin w_hg = w_f; w_hb = 8'hFF; end
         2'd2: begin w_hr = w_f; w_hg = 8'hFF; w_hb = 8'hFF - w_f; end
         default: begin w_hr = 8'hFF; w_hg = 8'hFF - w_f; end
      endcase
   end
`endif

   // Per-mode channel mapping.
   always_comb begin
      w_r = 8'd0;
      w_g = 8'd0;
      w_b = 8'd0;
      case (r_mode1)
         3'b000, 3'b100: begin
`ifdef COLOR_EXPAND_HEATMAP_EN
            w_r = w_hr; w_g = w_hg; w_b = w_hb;
`else
            w_r = r_v1; w_g = r_v1; w_b = r_v1;
`endif
         end
         3'b001: w_r = r_v1;
         3'b010: w_g = r_v1;
         3'b011: w_b = r_v1;
         3'b101: begin
            if (w_hi) w_r = w_m;
            else begin w_g = w_m; w_b = w_m; end
         end
         default: begin
            if (w_hi) w_b = w_m;
            else begin w_r = w_m; w_g = w_m; end
         end
      endcase
   end

   assign w_pack = {w_r[7:3], w_g[7:2], w_b[7:3]};

   // Stage 2: pack RGB565; invalid slots carry a zero pixel.
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         disp_pixel  <= 16'd0;
         disp_valid  <= 1'b0;
         disp_hcount <= 11'd0;
         disp_vcount <= 10'd0;
      end else begin
         disp_pixel  <= r_vld1 ? w_pack : 16'd0;
         disp_valid  <= r_vld1;
         disp_hcount <= r_h1;
         disp_vcount <= r_vc1;
      end
   end

   assign sel_active = r_sel;

endmodule

// File: tb/tb_color_expand.sv
// Directed bench for color_expand; expected values hand-computed.
module tb_color_expand;

   logic        clk_in = 1'b0;
   logic        rst_n_in;
   logic [7:0]  mod_pixel;
   logic        mod_valid;
   logic [10:0] mod_hcount;
   logic [9:0]  mod_vcount;
   logic [2:0]  selector;
   logic [15:0] disp_pixel;
   logic        disp_valid;
   logic [10:0] disp_hcount;
   logic [9:0]  disp_vcount;
   logic [2:0]  sel_active;

   int n_tot = 0;
   int n_bad = 0;

   color_expand dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in),
      .mod_pixel(mod_pixel), .mod_valid(mod_valid),
      .mod_hcount(mod_hcount), .mod_vcount(mod_vcount),
      .selector(selector),
      .disp_pixel(disp_pixel), .disp_valid(disp_valid),
      .disp_hcount(disp_hcount), .disp_vcount(disp_vcount),
      .sel_active(sel_active)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
      n_tot++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic drive(input logic vld, input logic [7:0] v, input logic [10:0] h,
                        input logic [9:0] vc, input logic [2:0] sel);
      mod_valid  = vld;
      mod_pixel  = v;
      mod_hcount = h;
      mod_vcount = vc;
      selector   = sel;
   endtask

   // Single pixel through the pipe, checked 2 clocks later.
   task automatic px(input string tag, input logic [7:0] v, input logic [10:0] h,
                     input logic [9:0] vc, input logic [2:0] sel, input logic [15:0] exp);
      drive(1'b1, v, h, vc, sel);
      step();
      mod_valid = 1'b0;
      step();
      chk({tag, "_vld"}, 16'(disp_valid), 16'd1);
      chk(tag, disp_pixel, exp);
   endtask

   initial begin
      rst_n_in = 1'b0;
      drive(1'b1, 8'hFF, 11'd0, 10'd0, 3'b001);
      // 1. reset held 3 clk with valid input
      repeat (3) step();
      chk("rst_vld", 16'(disp_valid), 16'd0);
      chk("rst_pix", disp_pixel, 16'h0000);
      chk("rst_sel", 16'(sel_active), 16'd0);
      rst_n_in = 1'b1;
      drive(1'b1, 8'hFF, 11'd5, 10'd3, 3'b000);
      step();
      mod_valid = 1'b0;
      chk("lat1_vld", 16'(disp_valid), 16'd0);
      step();
      chk("lat2_vld", 16'(disp_valid), 16'd1);
      chk("lat2_pix", disp_pixel, 16'hFFFF);

      // 2. gray mode and count passthrough
      px("gray_ff", 8'hFF, 11'd0, 10'd0, 3'b000, 16'hFFFF);
      px("gray_80", 8'h80, 11'd37, 10'd5, 3'b000, 16'h8410);
      chk("hcnt", 16'(disp_hcount), 16'd37);
      chk("vcnt", 16'(disp_vcount), 16'd5);

      // 3. mid-frame selector change ignored until frame start
      px("midsel", 8'hFF, 11'd100, 10'd20, 3'b001, 16'hFFFF);
      chk("midsel_act", 16'(sel_active), 16'd0);
      px("frm_r", 8'hFF, 11'd0, 10'd0, 3'b001, 16'hF800);
      chk("frm_act", 16'(sel_active), 16'd1);

      // other primaries
      px("g_ff", 8'hFF, 11'd0, 10'd0, 3'b010, 16'h07E0);
      px("b_ff", 8'hFF, 11'd0, 10'd0, 3'b011, 16'h001F);

      // 4. Cr / Cb diverging
      px("cr_80", 8'h80, 11'd0, 10'd0, 3'b101, 16'h0000);
      px("cr_c0", 8'hC0, 11'd1, 10'd0, 3'b101, 16'h8000);
      px("cr_00", 8'h00, 11'd2, 10'd0, 3'b101, 16'h07FF);
      px("cr_ff", 8'hFF, 11'd3, 10'd0, 3'b101, 16'hF800);
      px("cb_40", 8'h40, 11'd0, 10'd0, 3'b110, 16'h8400);
      px("cb_80", 8'h80, 11'd1, 10'd0, 3'b110, 16'h0000);
      px("cb7_c0", 8'hC0, 11'd0, 10'd0, 3'b111, 16'h0010);

      // 5. valid interleave 1,0,1 at full rate (mode 111)
      drive(1'b1, 8'hC0, 11'd1, 10'd1, 3'b111);
      step();
      drive(1'b0, 8'hC0, 11'd2, 10'd1, 3'b111);
      step();
      chk("il0_vld", 16'(disp_valid), 16'd1);
      chk("il0_pix", disp_pixel, 16'h0010);
      drive(1'b1, 8'h40, 11'd3, 10'd1, 3'b111);
      step();
      mod_valid = 1'b0;
      chk("il1_vld", 16'(disp_valid), 16'd0);
      chk("il1_pix", disp_pixel, 16'h0000);
      chk("il1_h", 16'(disp_hcount), 16'd2);
      step();
      chk("il2_vld", 16'(disp_valid), 16'd1);
      chk("il2_pix", disp_pixel, 16'h8400);

      // 6. modes 000/100: heatmap or gray depending on build
`ifdef COLOR_EXPAND_HEATMAP_EN
      px("m4_00", 8'h00, 11'd0, 10'd0, 3'b100, 16'h0000);
      px("m4_7f", 8'h7F, 11'd1, 10'd0, 3'b100, 16'h07FF);
      px("m4_ff", 8'hFF, 11'd2, 10'd0, 3'b100, 16'hF800);
`else
      px("m4_00", 8'h00, 11'd0, 10'd0, 3'b100, 16'h0000);
      px("m4_7f", 8'h7F, 11'd1, 10'd0, 3'b100, 16'h7BEF);
      px("m4_ff", 8'hFF, 11'd2, 10'd0, 3'b100, 16'hFFFF);
`endif

      // mid-frame reset discards in-flight pixel
      drive(1'b1, 8'hFF, 11'd4, 10'd0, 3'b100);
      step();
      mod_valid = 1'b0;
      rst_n_in  = 1'b0;
      step();
      rst_n_in = 1'b1;
      step();
      chk("mrst_vld", 16'(disp_valid), 16'd0);
      chk("mrst_sel", 16'(sel_active), 16'd0);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
